dpram_port_master: RTL and testbench
====================================

Name: dpram_port_master

Overview:
- Initiator for one port of the team's synchronous dual-port RAM, which uses a cs/wr/oe port with a bidirectional data bus.
- Accepts read/write requests on a valid/ready handshake and sequences the RAM pins with correct timing.
- Owns the tri-state data bus direction and returns read data on a response strobe.
- One instance per RAM port sits between a client (DMA, CPU bridge) and the RAM.

Parameters:
- ADDR_WIDTH, 4, RAM address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 8, RAM data width.
- TURNAROUND, 1, idle bus cycles inserted between a read and a following write (0 or 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  client request present.
- req_ready  out  1  block accepts a request this cycle.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_rdata  out  DATA_WIDTH  captured read data; held until the next capture.
- wr_ack  out  1  one-cycle pulse; write issued to the RAM.
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_data  inout  DATA_WIDTH  RAM port data bus.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0 while in reset, then 1 in IDLE.
  - rsp_valid=0, wr_ack=0, rsp_rdata=0.
  - ram_cs=ram_wr=ram_oe=0, ram_addr=0, ram_data=Z.
- Reset mid-operation aborts immediately. Any partially issued read is lost with no rsp_valid; the bus is released in the same cycle.
- All RAM pin outputs are registered (no combinational path from req_* to ram_*).
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, TURN.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid&&req_ready at a rising edge; addr and wdata are latched at that edge.
  - On handshake, go to WRITE if req_wr=1, else RD_ADDR.
- WRITE (1 cycle):
  - ram_cs=1, ram_wr=1, ram_oe=0; ram_addr and ram_data driven from the latched request.
  - RAM samples the write at the edge ending this cycle.
  - wr_ack pulses in the cycle after WRITE; next state is IDLE.
- RD_ADDR (1 cycle):
  - ram_cs=1, ram_wr=0, ram_oe=1, ram_data=Z.
  - The RAM registers its output at the edge ending this cycle.
- RD_DATA (1 cycle):
  - Same pin values as RD_ADDR; the RAM drives ram_data during this cycle.
  - rsp_rdata<=ram_data at the edge ending RD_DATA; rsp_valid=1 in the following cycle.
  - Next state is TURN if TURNAROUND=1, else IDLE.
- TURN (1 cycle): all RAM controls 0, bus Z, req_ready=0. Next state is IDLE.
- Latency from handshake edge:
  - Write: 1 cycle to pins; wr_ack at +2.
  - Read: rsp_valid at +3.
  - Maximum throughput: one write per 2 cycles; one read per 3 cycles (+TURNAROUND).
- Bus ownership rule: the block drives ram_data if and only if state==WRITE. It is Z in every other state, including during reset.
- Address: ram_addr holds its last value when idle. Values wrap naturally at 2**ADDR_WIDTH; no range check.
- req_ready=0 in every state except IDLE. req_valid held high while not ready is legal; the request is taken on return to IDLE.
- rsp_valid and wr_ack are never asserted in the same cycle.

Decomposition:
- Shared package dpram_pkg holds:
  - state enum (IDLE, WRITE, RD_ADDR, RD_DATA, TURN);
  - default ADDR_WIDTH/DATA_WIDTH constants shared with the RAM;
  - request struct {wr, addr, wdata}.
- One sub-module, dpram_bus_driver: registered output enable plus tri-state assign for ram_data, with a capture register for read data. The FSM stays in the top.

Test Plan:
- Reset → Z: assert rst_n=0 mid RD_DATA → next sample shows ram_cs=0, ram_oe=0, ram_data=Z, rsp_valid never pulses; after release, req_ready=1.
- Single write: write addr 3, data 8'hA5 → ram_cs=1, ram_wr=1, ram_addr=3, ram_data=A5 for exactly one cycle; wr_ack at +2; RAM model memory[3]=A5.
- Single read: preload memory[7]=8'h3C, then read 7 → ram_oe=1 for 2 cycles; rsp_valid at +3 with rsp_rdata=3C; ram_data never driven by the DUT.
- Read-then-write turnaround: read 7 immediately followed by write 7=8'h55, TURNAROUND=1 → one TURN cycle with all controls 0; no cycle where DUT and RAM both drive (no X on bus); a re-read returns 55.
- Backpressure: hold req_valid=1 with 4 alternating requests → each request is accepted only in IDLE; none dropped or duplicated; responses in order.
- Wrap: write addr 15 then addr 0 (ADDR_WIDTH=4) with distinct data → both read back correctly; ram_addr never exceeds 15.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM port master and the RAM it drives:
// default geometry, FSM state encoding and the client request record.
package dpram_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;

   // Explicit encodings keep the state values stable for older tooling.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      RD_ADDR = 3'd2,
      RD_DATA = 3'd3,
      TURN    = 3'd4
   } state_t;

   typedef struct packed {
      logic                      wr;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
   } dpram_req_t;

   // States in which the RAM chip select is asserted.
   function automatic logic is_ram_active(input state_t s);
      return (s == WRITE) || (s == RD_ADDR) || (s == RD_DATA);
   endfunction

endpackage

// File: rtl/dpram_bus_driver.sv
// Owns the bidirectional RAM data bus: a registered drive enable with the
// write data behind a tri-state, plus the capture register for read data.
module dpram_bus_driver
   import dpram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drive_next,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  capture,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic                  drive_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;

   // Drive enable follows the FSM one edge early so it lines up with WRITE;
   // reset clears it asynchronously so the bus is released immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drive_reg <= 1'b0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         drive_reg <= drive_next;
         if (load)
            wdata_reg <= wdata;
         if (capture)
            rdata_reg <= ram_data;
      end
   end

   assign ram_data = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
   assign rdata    = rdata_reg;

endmodule

// File: rtl/dpram_port_master.sv
// Initiator for one port of the synchronous dual-port RAM. Takes read/write
// requests on a valid/ready handshake and sequences cs/wr/oe with registered
// pins; read data comes back on a one-cycle rsp_valid strobe.
module dpram_port_master
   import dpram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TURNAROUND = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  wr_ack,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cs,
   output logic                  ram_wr,
   output logic                  ram_oe
);

   state_t                state_reg;
   state_t                state_next;
   logic                  handshake;
   logic                  ram_cs_reg;
   logic                  ram_wr_reg;
   logic                  ram_oe_reg;
   logic [ADDR_WIDTH-1:0] ram_addr_reg;
   logic                  rsp_valid_reg;
   logic                  wr_ack_reg;

   // Ready is low while reset is held, not just after the first edge.
   assign req_ready = rst_n && (state_reg == IDLE);
   assign handshake = req_valid && req_ready;

   // Next-state logic; every operation is a fixed-length walk back to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (handshake) state_next = req_wr ? WRITE : RD_ADDR;
         WRITE:   state_next = IDLE;
         RD_ADDR: state_next = RD_DATA;
         RD_DATA: state_next = (TURNAROUND != 0) ? TURN : IDLE;
         TURN:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State plus pins registered from the next state, so the pins are valid
   // for the whole of each state with no path from req_* to ram_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ram_cs_reg    <= 1'b0;
         ram_wr_reg    <= 1'b0;
         ram_oe_reg    <= 1'b0;
         ram_addr_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         wr_ack_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ram_cs_reg    <= is_ram_active(state_next);
         ram_wr_reg    <= (state_next == WRITE);
         ram_oe_reg    <= (state_next == RD_ADDR) || (state_next == RD_DATA);
         if (handshake)
            ram_addr_reg <= req_addr;
         rsp_valid_reg <= (state_reg == RD_DATA);
         wr_ack_reg    <= (state_reg == WRITE);
      end
   end

   dpram_bus_driver #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bus_driver (
      .clk        (clk),
      .rst_n      (rst_n),
      .drive_next (state_next == WRITE),
      .load       (handshake && req_wr),
      .wdata      (req_wdata),
      .capture    (state_reg == RD_DATA),
      .ram_data   (ram_data),
      .rdata      (rsp_rdata)
   );

   assign ram_cs    = ram_cs_reg;
   assign ram_wr    = ram_wr_reg;
   assign ram_oe    = ram_oe_reg;
   assign ram_addr  = ram_addr_reg;
   assign rsp_valid = rsp_valid_reg;
   assign wr_ack    = wr_ack_reg;

endmodule

// File: tb/tb_dpram_port_master.sv
// Bench for dpram_port_master: a behavioural RAM on the pin side and a
// transaction-level reference that schedules the expected pin activity.
module tb_dpram_port_master;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TA = 1;
   localparam int NC = 4096;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   wire           req_ready;
   wire           rsp_valid;
   wire  [DW-1:0] rsp_rdata;
   wire           wr_ack;
   wire  [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;
   wire           ram_cs;
   wire           ram_wr;
   wire           ram_oe;

   always #5 clk = ~clk;

   dpram_port_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TURNAROUND (TA)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .wr_ack    (wr_ack),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_cs    (ram_cs),
      .ram_wr    (ram_wr),
      .ram_oe    (ram_oe)
   );

   // Behavioural synchronous RAM: write sampled at the edge, read data
   // registered at the edge and driven while oe stays high.
   logic [DW-1:0] ram_mem [2**AW];
   logic          ram_rd_reg;
   logic [DW-1:0] ram_q;
   always @(posedge clk) begin
      if (ram_cs && ram_wr)
         ram_mem[ram_addr] <= ram_data;
      ram_rd_reg <= ram_cs && ram_oe && !ram_wr;
      ram_q      <= ram_mem[ram_addr];
   end
   wire ram_drive = ram_rd_reg && ram_cs && ram_oe;
   assign ram_data = ram_drive ? ram_q : {DW{1'bz}};

   // Reference model state: memory contents and per-cycle expectations.
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            free_at = 0;
   bit            in_reset = 1'b1;
   logic [DW-1:0] ref_mem [2**AW];
   bit            exp_cs [NC];
   bit            exp_wr [NC];
   bit            exp_oe [NC];
   bit            exp_ack [NC];
   bit            exp_rsp [NC];
   bit            exp_aset [NC];
   logic [DW-1:0] exp_data [NC];
   logic [DW-1:0] exp_rdata [NC];
   logic [AW-1:0] exp_addr [NC];
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_rdata = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: check this cycle's outputs against the schedule, then
   // present the next request and, if the model says it is taken, schedule it.
   task automatic do_cycle(input bit v, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output bit taken);
      bit exp_rdy;
      int c;
      @(negedge clk);
      cyc++;
      c = cyc;
      if (c + 8 >= NC) begin
         $display("[TB] FAIL cycle_budget got=%0d exp<%0d", c, NC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      if (exp_aset[c]) cur_addr = exp_addr[c];
      if (exp_rsp[c])  cur_rdata = exp_rdata[c];
      exp_rdy = !in_reset && (c >= free_at);
      check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_val("ram_cs",    32'(ram_cs),    32'(exp_cs[c]));
      check_val("ram_wr",    32'(ram_wr),    32'(exp_wr[c]));
      check_val("ram_oe",    32'(ram_oe),    32'(exp_oe[c]));
      check_val("ram_addr",  32'(ram_addr),  32'(cur_addr));
      check_val("wr_ack",    32'(wr_ack),    32'(exp_ack[c]));
      check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rsp[c]));
      check_val("rsp_rdata", 32'(rsp_rdata), 32'(cur_rdata));
      if (exp_wr[c])
         check_val("wr_bus", 32'(ram_data), 32'(exp_data[c]));
      if (ram_drive)
         check_val("bus_owner", 32'(ram_wr), 32'(0));
      taken = v && exp_rdy;
      if (taken) begin
         exp_aset[c+1] = 1'b1;
         exp_addr[c+1] = a;
         if (w) begin
            ref_mem[a]    = d;
            exp_cs[c+1]   = 1'b1;
            exp_wr[c+1]   = 1'b1;
            exp_data[c+1] = d;
            exp_ack[c+2]  = 1'b1;
            free_at       = c + 2;
         end else begin
            exp_cs[c+1]    = 1'b1;
            exp_oe[c+1]    = 1'b1;
            exp_cs[c+2]    = 1'b1;
            exp_oe[c+2]    = 1'b1;
            exp_rsp[c+3]   = 1'b1;
            exp_rdata[c+3] = ref_mem[a];
            free_at        = c + 3 + TA;
         end
      end
      req_valid = v;
      req_wr    = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit taken = 1'b0;
      int waits = 0;
      while (!taken && waits < 20) begin
         do_cycle(1'b1, w, a, d, taken);
         waits++;
      end
      check_val("accepted", 32'(taken), 32'(1));
      $display("[TB] cyc %0d %s addr=%0h data=%0h", cyc, w ? "WR" : "RD", a, w ? d : ref_mem[a]);
   endtask

   task automatic idle(input int k);
      bit t;
      repeat (k) do_cycle(1'b0, 1'b0, '0, '0, t);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", 32'(req_ready), 32'(0));
      check_val("rst_cs",    32'(ram_cs),    32'(0));
      check_val("rst_wr",    32'(ram_wr),    32'(0));
      check_val("rst_oe",    32'(ram_oe),    32'(0));
      check_val("rst_addr",  32'(ram_addr),  32'(0));
      check_val("rst_rsp",   32'(rsp_valid), 32'(0));
      check_val("rst_ack",   32'(wr_ack),    32'(0));
      check_val("rst_rdata", 32'(rsp_rdata), 32'(0));
      rst_n    = 1'b1;
      in_reset = 1'b0;
      #1;
      check_val("rel_ready", 32'(req_ready), 32'(1));

      // Define every location first so later reads have known contents
      for (int i = 0; i < 2**AW; i++)
         issue(1'b1, AW'(i), DW'($urandom));

      // Single write, then confirm the RAM itself holds it
      issue(1'b1, 4'd3, 8'hA5);
      idle(2);
      check_val("ram_mem3", 32'(ram_mem[3]), 32'(8'hA5));

      // Single read of a preloaded location
      issue(1'b1, 4'd7, 8'h3C);
      idle(1);
      issue(1'b0, 4'd7, '0);
      idle(4);

      // Read immediately followed by write to the same address, then re-read
      issue(1'b0, 4'd7, '0);
      issue(1'b1, 4'd7, 8'h55);
      issue(1'b0, 4'd7, '0);
      idle(4);

      // Valid held high across four alternating requests
      issue(1'b1, 4'd2, 8'h11);
      issue(1'b0, 4'd2, '0);
      issue(1'b1, 4'd4, 8'h22);
      issue(1'b0, 4'd4, '0);
      idle(4);

      // Address extremes
      issue(1'b1, 4'd15, 8'hF0);
      issue(1'b1, 4'd0,  8'h0F);
      issue(1'b0, 4'd15, '0);
      issue(1'b0, 4'd0,  '0);
      idle(4);

      // Random traffic with occasional gaps
      repeat (250) begin
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
         issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 2**AW - 1)), DW'($urandom));
      end
      idle(6);

      // Reset asserted in the middle of RD_DATA aborts the read
      issue(1'b0, 4'd9, '0);
      idle(2);
      rst_n = 1'b0;
      in_reset = 1'b1;
      for (int i = cyc + 1; i < cyc + 8; i++) begin
         exp_cs[i] = 0; exp_wr[i] = 0; exp_oe[i] = 0;
         exp_ack[i] = 0; exp_rsp[i] = 0; exp_aset[i] = 0;
      end
      cur_addr  = '0;
      cur_rdata = '0;
      #1;
      check_val("abort_cs",    32'(ram_cs),    32'(0));
      check_val("abort_oe",    32'(ram_oe),    32'(0));
      check_val("abort_wr",    32'(ram_wr),    32'(0));
      check_val("abort_ready", 32'(req_ready), 32'(0));
      check_val("abort_drive", 32'(ram_drive), 32'(0));
      check_val("abort_rdata", 32'(rsp_rdata), 32'(0));
      idle(3);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      free_at  = cyc;
      #1;
      check_val("abort_rel_ready", 32'(req_ready), 32'(1));
      idle(3);
      issue(1'b1, 4'd9, 8'hC3);
      issue(1'b0, 4'd9, '0);
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
